// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard, forwarding and stall controller.
package pipe_pkg;

    // Widest register address a tracker entry can hold
    localparam int RD_W = 8;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EXE = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_e;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } dm_state_e;

    typedef struct packed {
        logic            valid;
        logic [RD_W-1:0] rd;
        logic            we;
        logic            load;
    } stage_entry_t;

    function automatic logic entry_hit(stage_entry_t e, logic [RD_W-1:0] a);
        return e.valid && e.we && (e.rd == a);
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Per-source comparator against the EXE/MEM/WB tracker entries.
// PIPE_HAZARD_FWD_EN selects forwarding; otherwise every match is a hazard.
module hazard_match
    import pipe_pkg::*;
#(
    parameter int REG_AW = 5
)(
    input  logic [REG_AW-1:0] addr,
    input  logic              rd_en,
    input  stage_entry_t      exe,
    input  stage_entry_t      mem,
    input  stage_entry_t      wb,
    output logic              hazard,
    output fwd_sel_e          sel
);

    logic [RD_W-1:0] a;
    logic [2:0]      hit;

    always_comb begin
        a = '0;
        a[REG_AW-1:0] = addr;
        hit = '0;
        if (rd_en) begin
            hit[0] = entry_hit(exe, a);
            hit[1] = entry_hit(mem, a);
            hit[2] = entry_hit(wb, a);
        end
`ifdef PIPE_HAZARD_FWD_EN
        // A load in EXE has no data yet: stall instead of forwarding
        hazard = hit[0] && exe.load;
        sel = FWD_RF;
        if (hit[0]) begin
            sel = exe.load ? FWD_RF : FWD_EXE;
        end else if (hit[1]) begin
            sel = FWD_MEM;
        end else if (hit[2]) begin
            sel = FWD_WB;
        end
`else
        hazard = |hit;
        sel = FWD_RF;
`endif
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and stall controller for the 5-stage pipeline.
// Forwarding is enabled by defining PIPE_HAZARD_FWD_EN.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
)(
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1_addr,
    input  logic [REG_AW-1:0] id_rs2_addr,
    input  logic              id_rs1_rd,
    input  logic              id_rs2_rd,
    input  logic [REG_AW-1:0] id_rd_addr,
    input  logic              id_rd_we,
    input  logic              id_is_load,
    input  logic              branch_taken,
    input  logic              mem_dm_req,
    input  logic              dm_ready,
    output logic              pc_stall,
    output logic              ifid_stall,
    output logic              idexe_stall,
    output logic              exemem_stall,
    output logic              ifid_flush,
    output logic              idexe_flush,
    output logic              memwb_bubble,
    output logic [1:0]        fwd_sel1,
    output logic [1:0]        fwd_sel2,
    output logic              dm_err,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int TO_W = $clog2(MEM_TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    stage_entry_t    exe_q, mem_q, wb_q, id_entry;
    dm_state_e       state;
    logic [TO_W-1:0] to_cnt;
    logic            hz1, hz2, hazard;
    logic            frozen, timeout, use_stall, br_flush;
    fwd_sel_e        sel1, sel2;

    hazard_match #(.REG_AW(REG_AW)) u_match1 (
        .addr   (id_rs1_addr),
        .rd_en  (id_rs1_rd),
        .exe    (exe_q),
        .mem    (mem_q),
        .wb     (wb_q),
        .hazard (hz1),
        .sel    (sel1)
    );

    hazard_match #(.REG_AW(REG_AW)) u_match2 (
        .addr   (id_rs2_addr),
        .rd_en  (id_rs2_rd),
        .exe    (exe_q),
        .mem    (mem_q),
        .wb     (wb_q),
        .hazard (hz2),
        .sel    (sel2)
    );

    always_comb begin
        id_entry = '0;
        id_entry.valid = 1'b1;
        id_entry.rd[REG_AW-1:0] = id_rd_addr;
        id_entry.we = id_rd_we;
        id_entry.load = id_is_load;
    end

    // The timeout cycle completes the access, so it is not frozen
    always_comb begin
        timeout = (state == WAIT) && !dm_ready && (to_cnt == TO_LAST);
        if (state == WAIT) begin
            frozen = !dm_ready && !timeout;
        end else begin
            frozen = mem_dm_req && !dm_ready;
        end
        hazard = hz1 || hz2;
        br_flush = !frozen && branch_taken;
        use_stall = !frozen && !branch_taken && hazard;
    end

    assign pc_stall     = frozen || use_stall;
    assign ifid_stall   = frozen || use_stall;
    assign idexe_stall  = frozen;
    assign exemem_stall = frozen;
    assign memwb_bubble = frozen;
    assign ifid_flush   = br_flush;
    assign idexe_flush  = br_flush || use_stall;
    assign fwd_sel1     = sel1;
    assign fwd_sel2     = sel2;

    always_ff @(posedge clk) begin
        if (!rst) begin
            exe_q <= '0;
            mem_q <= '0;
            wb_q <= '0;
            stall_cnt <= '0;
        end else begin
            if (!frozen) begin
                wb_q <= mem_q;
                mem_q <= exe_q;
                exe_q <= idexe_flush ? stage_entry_t'('0) : id_entry;
            end
            if ((frozen || use_stall) && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= RUN;
            to_cnt <= '0;
            dm_err <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (mem_dm_req && !dm_ready) begin
                        state <= WAIT;
                        to_cnt <= '0;
                    end
                end
                WAIT: begin
                    if (dm_ready) begin
                        state <= RUN;
                    end else if (timeout) begin
                        state <= RUN;
                        dm_err <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table, corner
// sequences, and random stimulus against a queue-based pipeline model.
module tb_pipe_hazard_ctrl;

    localparam int TO = 16;
`ifdef PIPE_HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    localparam logic [6:0] C_NO  = 7'b0000000;
    localparam logic [6:0] C_LU  = 7'b1100010;
    localparam logic [6:0] C_BR  = 7'b0000110;
    localparam logic [6:0] C_FRZ = 7'b1111001;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic       id_rs1_rd, id_rs2_rd, id_rd_we, id_is_load;
    logic       branch_taken, mem_dm_req, dm_ready;
    logic       pc_stall, ifid_stall, idexe_stall, exemem_stall;
    logic       ifid_flush, idexe_flush, memwb_bubble;
    logic [1:0] fwd_sel1, fwd_sel2;
    logic       dm_err;
    logic [15:0] stall_cnt;
    logic [6:0] ctl;

    int checks = 0;
    int errors = 0;

    pipe_hazard_ctrl #(.REG_AW(5), .MEM_TIMEOUT(TO), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs1_addr  (id_rs1_addr),
        .id_rs2_addr  (id_rs2_addr),
        .id_rs1_rd    (id_rs1_rd),
        .id_rs2_rd    (id_rs2_rd),
        .id_rd_addr   (id_rd_addr),
        .id_rd_we     (id_rd_we),
        .id_is_load   (id_is_load),
        .branch_taken (branch_taken),
        .mem_dm_req   (mem_dm_req),
        .dm_ready     (dm_ready),
        .pc_stall     (pc_stall),
        .ifid_stall   (ifid_stall),
        .idexe_stall  (idexe_stall),
        .exemem_stall (exemem_stall),
        .ifid_flush   (ifid_flush),
        .idexe_flush  (idexe_flush),
        .memwb_bubble (memwb_bubble),
        .fwd_sel1     (fwd_sel1),
        .fwd_sel2     (fwd_sel2),
        .dm_err       (dm_err),
        .stall_cnt    (stall_cnt)
    );

    assign ctl = {pc_stall, ifid_stall, idexe_stall, exemem_stall,
                  ifid_flush, idexe_flush, memwb_bubble};

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [4:0] rs1; logic en1;
        logic [4:0] rs2; logic en2;
        logic [4:0] rd;  logic we; logic ld; logic br;
    } in_t;

    typedef struct {
        in_t        i;
        logic [6:0] ctl;
        logic [1:0] s1;
        logic [1:0] s2;
    } vec_t;

    typedef struct { bit v; int rd; bit we; bit ld; } inst_t;

    vec_t  tv[$];
    inst_t hist[$];

    function automatic in_t mki(int rs1, bit en1, int rs2, bit en2,
                                int rd, bit we, bit ld, bit br);
        in_t r;
        r.rs1 = 5'(rs1); r.en1 = en1; r.rs2 = 5'(rs2); r.en2 = en2;
        r.rd = 5'(rd); r.we = we; r.ld = ld; r.br = br;
        return r;
    endfunction

    function automatic vec_t mkv(in_t i, logic [6:0] c, int s1, int s2);
        vec_t v;
        v.i = i; v.ctl = c; v.s1 = 2'(s1); v.s2 = 2'(s2);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input in_t i);
        id_rs1_addr = i.rs1; id_rs1_rd = i.en1;
        id_rs2_addr = i.rs2; id_rs2_rd = i.en2;
        id_rd_addr = i.rd; id_rd_we = i.we; id_is_load = i.ld;
        branch_taken = i.br;
        mem_dm_req = 1'b0; dm_ready = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(mki(0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // ---------------- reference model ----------------
    bit m_busy, m_err;
    int m_wait, m_cnt;

    function automatic int first_hit(int a, bit en);
        if (!en) return -1;
        for (int k = 0; k < 3; k++)
            if (hist[k].v && hist[k].we && hist[k].rd == a) return k;
        return -1;
    endfunction

    task automatic model_reset();
        inst_t b;
        b = '{v: 0, rd: 0, we: 0, ld: 0};
        hist.delete();
        repeat (3) hist.push_back(b);
        m_busy = 0; m_err = 0; m_wait = 0; m_cnt = 0;
    endtask

    task automatic run_random(input int n);
        int stuck = 0;
        for (int c = 0; c < n; c++) begin
            in_t   i;
            inst_t nw, bub;
            int    h1, h2, s1, s2;
            bit    frz, lu, lue;
            logic [6:0] ec;
            i = mki($urandom_range(0, 3), $urandom_range(0, 1),
                    $urandom_range(0, 3), $urandom_range(0, 1),
                    $urandom_range(0, 3), $urandom_range(0, 1),
                    $urandom_range(0, 2) == 0, $urandom_range(0, 6) == 0);
            drive(i);
            if ($urandom_range(0, 149) == 0) stuck = 20;
            mem_dm_req = $urandom_range(0, 3) == 0;
            dm_ready = (stuck > 0) ? 1'b0 : ($urandom_range(0, 9) < 6);
            if (stuck > 0) stuck--;
            #1;
            frz = (m_busy || mem_dm_req) && !dm_ready && (m_wait < TO);
            h1 = first_hit(i.rs1, i.en1);
            h2 = first_hit(i.rs2, i.en2);
            if (FWD) begin
                lu = (h1 == 0 || h2 == 0) && hist[0].ld;
                s1 = (h1 < 0 || (h1 == 0 && hist[0].ld)) ? 0 : h1 + 1;
                s2 = (h2 < 0 || (h2 == 0 && hist[0].ld)) ? 0 : h2 + 1;
            end else begin
                lu = (h1 >= 0) || (h2 >= 0);
                s1 = 0;
                s2 = 0;
            end
            lue = !frz && !i.br && lu;
            ec = frz ? C_FRZ : (i.br ? C_BR : (lu ? C_LU : C_NO));
            chk($sformatf("rand%0d ctl", c), ctl, ec);
            chk($sformatf("rand%0d sel1", c), fwd_sel1, s1);
            chk($sformatf("rand%0d sel2", c), fwd_sel2, s2);
            chk($sformatf("rand%0d dm_err", c), dm_err, m_err);
            chk($sformatf("rand%0d stall_cnt", c), stall_cnt, m_cnt);
            if ((frz || lue) && m_cnt < 65535) m_cnt++;
            if (!frz) begin
                bub = '{v: 0, rd: 0, we: 0, ld: 0};
                nw = '{v: 1, rd: int'(i.rd), we: i.we, ld: i.ld};
                hist.push_front((i.br || lue) ? bub : nw);
                void'(hist.pop_back());
            end
            if (frz) begin
                m_busy = 1; m_wait++;
            end else if (m_busy) begin
                if (!dm_ready) m_err = 1;
                m_busy = 0; m_wait = 0;
            end
            tick();
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        rst = 1'b0;
        drive(mki(0, 0, 0, 0, 0, 0, 0, 0));
        do_reset();
        #1;
        chk("reset ctl", ctl, C_NO);
        chk("reset sel1", fwd_sel1, 0);
        chk("reset sel2", fwd_sel2, 0);
        chk("reset dm_err", dm_err, 0);
        chk("reset stall_cnt", stall_cnt, 0);

        if (FWD) begin
            tv.push_back(mkv(mki(1, 1, 2, 1, 3, 1, 0, 0), C_NO, 0, 0));
            tv.push_back(mkv(mki(3, 1, 1, 1, 4, 1, 0, 0), C_NO, 1, 0));
            tv.push_back(mkv(mki(0, 0, 3, 1, 6, 1, 0, 0), C_NO, 0, 2));
            tv.push_back(mkv(mki(2, 1, 0, 0, 5, 1, 1, 0), C_NO, 0, 0));
            tv.push_back(mkv(mki(5, 1, 4, 1, 7, 1, 0, 0), C_LU, 0, 3));
            tv.push_back(mkv(mki(5, 1, 4, 1, 7, 1, 0, 0), C_NO, 2, 0));
            tv.push_back(mkv(mki(0, 0, 0, 0, 8, 1, 1, 0), C_NO, 0, 0));
            tv.push_back(mkv(mki(8, 1, 0, 0, 9, 1, 0, 1), C_BR, 0, 0));
            tv.push_back(mkv(mki(0, 0, 0, 0, 0, 0, 0, 0), C_NO, 0, 0));
            tv.push_back(mkv(mki(0, 0, 0, 0, 0, 1, 0, 0), C_NO, 0, 0));
            tv.push_back(mkv(mki(0, 1, 0, 0, 0, 0, 0, 0), C_NO, 1, 0));
        end else begin
            tv.push_back(mkv(mki(1, 1, 2, 1, 3, 1, 0, 0), C_NO, 0, 0));
            tv.push_back(mkv(mki(3, 1, 1, 1, 4, 1, 0, 0), C_LU, 0, 0));
            tv.push_back(mkv(mki(3, 1, 1, 1, 4, 1, 0, 0), C_LU, 0, 0));
            tv.push_back(mkv(mki(3, 1, 1, 1, 4, 1, 0, 0), C_LU, 0, 0));
            tv.push_back(mkv(mki(3, 1, 1, 1, 4, 1, 0, 0), C_NO, 0, 0));
            tv.push_back(mkv(mki(0, 0, 0, 0, 5, 1, 1, 0), C_NO, 0, 0));
            tv.push_back(mkv(mki(5, 1, 0, 0, 9, 1, 0, 1), C_BR, 0, 0));
            tv.push_back(mkv(mki(0, 0, 0, 0, 0, 0, 0, 0), C_NO, 0, 0));
            tv.push_back(mkv(mki(0, 0, 0, 0, 0, 1, 0, 0), C_NO, 0, 0));
            tv.push_back(mkv(mki(0, 1, 0, 0, 0, 0, 0, 0), C_LU, 0, 0));
        end
        foreach (tv[k]) begin
            drive(tv[k].i);
            #1;
            chk($sformatf("vec%0d ctl", k), ctl, tv[k].ctl);
            chk($sformatf("vec%0d sel1", k), fwd_sel1, tv[k].s1);
            chk($sformatf("vec%0d sel2", k), fwd_sel2, tv[k].s2);
            tick();
        end
        chk("table stall_cnt", stall_cnt, FWD ? 1 : 4);

        // 3-cycle DM wait with a branch pending underneath the freeze
        do_reset();
        drive(mki(0, 0, 0, 0, 9, 1, 0, 0));
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(mki(9, 1, 0, 0, 1, 1, 0, 1));
            mem_dm_req = 1'b1;
            dm_ready = 1'b0;
            #1;
            chk($sformatf("freeze%0d ctl", k), ctl, C_FRZ);
            chk($sformatf("freeze%0d sel1", k), fwd_sel1, FWD ? 1 : 0);
            tick();
        end
        drive(mki(9, 1, 0, 0, 1, 1, 0, 1));
        mem_dm_req = 1'b1;
        #1;
        chk("release ctl", ctl, C_BR);
        chk("release sel1", fwd_sel1, FWD ? 1 : 0);
        tick();
        chk("freeze stall_cnt", stall_cnt, 3);
        drive(mki(9, 1, 0, 0, 1, 1, 0, 0));
        #1;
        chk("held tracker ctl", ctl, FWD ? C_NO : C_LU);
        chk("held tracker sel1", fwd_sel1, FWD ? 2 : 0);
        tick();
        chk("after hold stall_cnt", stall_cnt, FWD ? 3 : 4);

        // DM timeout
        do_reset();
        mem_dm_req = 1'b1;
        dm_ready = 1'b0;
        #1;
        n = 0;
        while (memwb_bubble && n < 100) begin
            n++;
            tick();
        end
        chk("timeout frozen cycles", n, TO);
        chk("dm_err before timeout edge", dm_err, 0);
        tick();
        mem_dm_req = 1'b0;
        #1;
        chk("dm_err after timeout", dm_err, 1);
        chk("after timeout ctl", ctl, C_NO);
        chk("timeout stall_cnt", stall_cnt, TO);
        tick();
        chk("dm_err sticky", dm_err, 1);

        // reset in the middle of a freeze
        mem_dm_req = 1'b1;
        dm_ready = 1'b0;
        tick();
        chk("mid-freeze bubble", memwb_bubble, 1);
        rst = 1'b0;
        mem_dm_req = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("post-reset ctl", ctl, C_NO);
        chk("post-reset dm_err", dm_err, 0);
        chk("post-reset stall_cnt", stall_cnt, 0);

        do_reset();
        model_reset();
        run_random(3000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
